// File: rtl/operand_fetch.sv
// Operand fetch stage for RV32I: resolves rs1/rs2 with write-back bypass,
// tracks pending destinations in a scoreboard and hands bundles to execute.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [NREG*XLEN-1:0] x_flat,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           id_rd,
    input  logic                 id_rd_wen,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [4:0]           ex_rd,
    output logic                 ex_rd_wen,
    output logic [NREG-1:0]      busy
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            wb_hit_rs1;
    logic            wb_hit_rs2;
    logic            wb_hit_rd;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            rd_pend;
    logic            hazard;
    logic            accept;
    logic [NREG-1:0] busy_next;

    // x0 reads as zero; a same-cycle write-back beats the stale register value.
    function automatic logic [XLEN-1:0] read_src(
        input logic [4:0]           src,
        input logic                 bypass,
        input logic [XLEN-1:0]      bypass_data,
        input logic [NREG*XLEN-1:0] regs
    );
        logic [XLEN-1:0] val;
        val = '0;
        if (src != 5'd0) begin
            if (bypass)
                val = bypass_data;
            else
                val = regs[{src, 5'b00000} +: XLEN];
        end
        return val;
    endfunction

    assign wb_hit_rs1 = wb_en && (wb_addr == id_rs1);
    assign wb_hit_rs2 = wb_en && (wb_addr == id_rs2);
    assign wb_hit_rd  = wb_en && (wb_addr == id_rd);

    assign rs1_val = read_src(id_rs1, wb_hit_rs1, wb_data, x_flat);
    assign rs2_val = read_src(id_rs2, wb_hit_rs2, wb_data, x_flat);

    // A pending write that lands this very cycle no longer blocks the reader.
    assign rs1_pend = (id_rs1 != 5'd0) && busy[id_rs1] && !wb_hit_rs1;
    assign rs2_pend = (id_rs2 != 5'd0) && busy[id_rs2] && !wb_hit_rs2;
    assign rd_pend  = (id_rd  != 5'd0) && busy[id_rd]  && !wb_hit_rd;

    assign hazard   = rs1_pend || rs2_pend || (id_rd_wen && rd_pend);
    assign id_ready = !hazard && !flush && (!ex_valid || ex_ready);
    assign accept   = id_valid && id_ready;

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        busy_next = busy;
        if (wb_en && (wb_addr != 5'd0))
            busy_next[wb_addr] = 1'b0;
        if (accept && id_rd_wen && (id_rd != 5'd0))
            busy_next[id_rd] = 1'b1;
        // Squashing the held instruction releases its destination last, so it wins.
        if (flush && ex_valid && ex_rd_wen && (ex_rd != 5'd0))
            busy_next[ex_rd] = 1'b0;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!RSTN) begin
            ex_valid    <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rd       <= 5'd0;
            ex_rd_wen   <= 1'b0;
            busy        <= '0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                ex_valid    <= 1'b1;
                ex_rs1_data <= rs1_val;
                ex_rs2_data <= rs2_val;
                ex_rd       <= id_rd;
                ex_rd_wen   <= id_rd_wen;
            end else if (ex_ready || flush) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, randomized
// traffic against a rule-level reference model, and an async reset mid-transfer.
module tb_operand_fetch;

    logic          CLK;
    logic          RSTN;
    logic [1023:0] x_flat;
    logic          id_valid;
    logic          id_ready;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic [4:0]    id_rd;
    logic          id_rd_wen;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [31:0]   ex_rs1_data;
    logic [31:0]   ex_rs2_data;
    logic [4:0]    ex_rd;
    logic          ex_rd_wen;
    logic [31:0]   busy;

    int errors = 0;
    int checks = 0;

    operand_fetch dut (
        .CLK(CLK), .RSTN(RSTN), .x_flat(x_flat),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv;
        logic [4:0]  r1, r2, rd;
        logic        w;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        er, fl;
        logic        e_rdy, e_v;
        logic [31:0] e1, e2;
        logic [4:0]  erd;
        logic        ew;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic w, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic er,
                       input logic fl, input logic e_rdy, input logic e_v,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic [4:0] erd, input logic ew, input logic [31:0] eb);
        vec_t v;
        v.iv = iv; v.r1 = r1; v.r2 = r2; v.rd = rd; v.w = w;
        v.we = we; v.wa = wa; v.wd = wd; v.er = er; v.fl = fl;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e1 = e1; v.e2 = e2;
        v.erd = erd; v.ew = ew; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_wen = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        idle_inputs();
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Reference model state: the in-flight bundle and the set of pending writers.
    bit          m_valid;
    logic [31:0] m_rs1, m_rs2;
    logic [4:0]  m_rd;
    bit          m_wen;
    bit          m_pending[32];

    function automatic logic [31:0] m_src(input logic [4:0] a);
        int idx;
        idx = int'(a);
        if (idx == 0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return x_flat[idx*32 +: 32];
    endfunction

    function automatic bit m_blocked(input logic [4:0] a);
        int idx;
        idx = int'(a);
        return idx != 0 && m_pending[idx] && !(wb_en && wb_addr == a);
    endfunction

    function automatic logic [31:0] m_busy_word();
        logic [31:0] w;
        w = '0;
        for (int i = 1; i < 32; i++) w[i] = m_pending[i];
        return w;
    endfunction

    initial begin
        RSTN = 1'b0;
        x_flat = '0;
        idle_inputs();

        // Reset values
        do_reset();
        check("reset ex_valid", ex_valid, 0);
        check("reset ex_rs1_data", ex_rs1_data, 0);
        check("reset ex_rs2_data", ex_rs2_data, 0);
        check("reset ex_rd", ex_rd, 0);
        check("reset ex_rd_wen", ex_rd_wen, 0);
        check("reset busy", busy, 0);

        for (int i = 0; i < 32; i++) x_flat[i*32 +: 32] = 32'h1000 + i;
        x_flat[0 +: 32]    = 32'hFFFF_FFFF;
        x_flat[5*32 +: 32] = 32'h11;
        x_flat[6*32 +: 32] = 32'h22;

        //   iv r1 r2 rd w   we wa wd         er fl  rdy v  e1        e2        erd ew busy
        add(1, 5, 6, 7, 1,  0, 0, 0,          1, 0,  1, 1, 'h11,     'h22,     7,  1, 'h80);
        add(1, 7, 0, 8, 1,  0, 0, 0,          1, 0,  0, 0, 0,        0,        0,  0, 'h80);
        add(1, 7, 0, 8, 1,  1, 7, 'hABCD,     1, 0,  1, 1, 'hABCD,   0,        8,  1, 'h100);
        add(1, 0, 0, 0, 0,  1, 0, 5,          1, 0,  1, 1, 0,        0,        0,  0, 'h100);
        add(1, 1, 2, 9, 1,  0, 0, 0,          1, 0,  1, 1, 'h1001,   'h1002,   9,  1, 'h300);
        add(1, 3, 4, 10, 1, 1, 1, 'hDEAD,     0, 0,  0, 1, 'h1001,   'h1002,   9,  1, 'h300);
        add(1, 3, 4, 10, 1, 0, 0, 0,          0, 0,  0, 1, 'h1001,   'h1002,   9,  1, 'h300);
        add(1, 3, 4, 10, 1, 0, 0, 0,          0, 0,  0, 1, 'h1001,   'h1002,   9,  1, 'h300);
        add(1, 3, 4, 10, 1, 0, 0, 0,          0, 1,  0, 0, 0,        0,        0,  0, 'h100);
        add(1, 3, 4, 10, 1, 0, 0, 0,          1, 0,  1, 1, 'h1003,   'h1004,   10, 1, 'h500);
        add(1, 5, 6, 12, 1, 0, 0, 0,          0, 0,  0, 1, 'h1003,   'h1004,   10, 1, 'h500);
        add(1, 5, 6, 12, 1, 0, 0, 0,          0, 0,  0, 1, 'h1003,   'h1004,   10, 1, 'h500);
        add(1, 5, 6, 12, 1, 0, 0, 0,          0, 0,  0, 1, 'h1003,   'h1004,   10, 1, 'h500);
        add(1, 5, 6, 12, 1, 0, 0, 0,          1, 0,  1, 1, 'h11,     'h22,     12, 1, 'h1500);
        add(1, 0, 0, 3, 1,  1, 3, 'h77,       1, 0,  1, 1, 0,        0,        3,  1, 'h1508);
        add(1, 0, 0, 3, 1,  0, 0, 0,          1, 0,  0, 0, 0,        0,        0,  0, 'h1508);
        add(1, 0, 0, 3, 1,  1, 3, 'h55,       1, 0,  1, 1, 0,        0,        3,  1, 'h1508);
        add(0, 0, 0, 3, 0,  1, 3, 'h55,       1, 0,  1, 0, 0,        0,        0,  0, 'h1500);
        add(1, 0, 12, 0, 0, 0, 0, 0,          1, 0,  0, 0, 0,        0,        0,  0, 'h1500);
        add(1, 1, 2, 12, 0, 0, 0, 0,          1, 0,  1, 1, 'h1001,   'h1002,   12, 0, 'h1500);
        add(1, 9, 9, 0, 0,  1, 9, 'hCAFE,     1, 0,  1, 1, 'hCAFE,   'hCAFE,   0,  0, 'h1500);

        for (int i = 0; i < vecs.size(); i++) begin
            id_valid = vecs[i].iv; id_rs1 = vecs[i].r1; id_rs2 = vecs[i].r2;
            id_rd = vecs[i].rd; id_rd_wen = vecs[i].w;
            wb_en = vecs[i].we; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            ex_ready = vecs[i].er; flush = vecs[i].fl;
            #2;
            check($sformatf("vec%0d id_ready", i), id_ready, vecs[i].e_rdy);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d ex_valid", i), ex_valid, vecs[i].e_v);
            if (vecs[i].e_v) begin
                check($sformatf("vec%0d ex_rs1_data", i), ex_rs1_data, vecs[i].e1);
                check($sformatf("vec%0d ex_rs2_data", i), ex_rs2_data, vecs[i].e2);
                check($sformatf("vec%0d ex_rd", i), ex_rd, vecs[i].erd);
                check($sformatf("vec%0d ex_rd_wen", i), ex_rd_wen, vecs[i].ew);
            end
            check($sformatf("vec%0d busy", i), busy, vecs[i].eb);
        end

        // Randomized traffic against the reference model
        do_reset();
        m_valid = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wen = 0;
        for (int i = 0; i < 32; i++) m_pending[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit exp_ready, acc, hz;
            for (int i = 0; i < 32; i++) x_flat[i*32 +: 32] = $urandom;
            id_valid  = ($urandom_range(0, 3) != 0);
            id_rs1    = 5'($urandom_range(0, 7));
            id_rs2    = 5'($urandom_range(0, 7));
            id_rd     = 5'($urandom_range(0, 7));
            id_rd_wen = 1'($urandom_range(0, 1));
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            ex_ready  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #2;
            hz = m_blocked(id_rs1) || m_blocked(id_rs2) || (id_rd_wen && m_blocked(id_rd));
            exp_ready = !hz && !flush && (!m_valid || ex_ready);
            acc = id_valid && exp_ready;
            check($sformatf("rnd%0d id_ready", cyc), id_ready, exp_ready);

            if (wb_en && wb_addr != 0) m_pending[wb_addr] = 0;
            if (acc && id_rd_wen && id_rd != 0) m_pending[id_rd] = 1;
            if (flush && m_valid && m_wen && m_rd != 0) m_pending[m_rd] = 0;
            if (acc) begin
                m_rs1 = m_src(id_rs1); m_rs2 = m_src(id_rs2);
                m_rd = id_rd; m_wen = id_rd_wen; m_valid = 1;
            end else if (ex_ready || flush) begin
                m_valid = 0;
            end

            @(posedge CLK);
            #1;
            check($sformatf("rnd%0d ex_valid", cyc), ex_valid, m_valid);
            if (m_valid) begin
                check($sformatf("rnd%0d ex_rs1_data", cyc), ex_rs1_data, m_rs1);
                check($sformatf("rnd%0d ex_rs2_data", cyc), ex_rs2_data, m_rs2);
                check($sformatf("rnd%0d ex_rd", cyc), ex_rd, m_rd);
                check($sformatf("rnd%0d ex_rd_wen", cyc), ex_rd_wen, m_wen);
            end
            check($sformatf("rnd%0d busy", cyc), busy, m_busy_word());
        end

        // Asynchronous reset with a bundle held and a destination pending
        do_reset();
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd0; id_rd = 5'd4; id_rd_wen = 1'b1;
        ex_ready = 1'b0;
        @(posedge CLK);
        #1;
        check("pre-reset ex_valid", ex_valid, 1);
        check("pre-reset busy", busy, 32'h10);
        id_valid = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        check("async reset ex_valid", ex_valid, 0);
        check("async reset busy", busy, 0);
        check("async reset ex_rd", ex_rd, 0);
        check("async reset ex_rs1_data", ex_rs1_data, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
